reg8_load_arbiter: RTL
======================

// Module: reg8_load_arbiter
// PURPOSE
//   Arbitrates two requesters (A, B) for write access to one shared WIDTH-bit holding register.
//   Implements the register and its load/hold select internally, and sequences every write
//   with a four-phase REQ/ACK handshake.
//   Sits between switch/debounce front-ends (or other producers) and the LEDR display path.
//   Q is the register contents and drives the display directly.
// PARAMETERS
//   WIDTH  8  data width of the shared register and of both data inputs
// PORTS
//   CLK       in   1      rising-edge clock
//   RST       in   1      asynchronous, active-high reset
//   REQ_A     in   1      requester A write request (level, four-phase)
//   DATA_A    in   WIDTH  requester A write data
//   REQ_B     in   1      requester B write request (level, four-phase)
//   DATA_B    in   WIDTH  requester B write data
//   ACK_A     out  1      one-cycle pulse: A's data has been written
//   ACK_B     out  1      one-cycle pulse: B's data has been written
//   Q         out  WIDTH  shared register contents
//   BUSY      out  1      high whenever state != IDLE
//   LAST_SRC  out  1      source of the last completed write (0=A, 1=B)
// BEHAVIOUR
//   Reset (RST=1, asynchronous; overrides everything, including mid-transaction):
//     - state=IDLE; Q=0; ACK_A=ACK_B=0; BUSY=0; LAST_SRC=1.
//   FSM states: IDLE, LOAD, ACK, RELEASE. Grant select gsel is latched when leaving IDLE.
//   IDLE:
//     - No REQ: Q holds.
//     - One REQ high: gsel=that requester; ->LOAD.
//     - Both high: winner per CONFIGURATION; ->LOAD.
//   LOAD:
//     - REQ_gsel still high: Q<=DATA_gsel at the edge; ACK_gsel<=1; LAST_SRC<=gsel; ->ACK.
//     - REQ_gsel dropped (abort): no write, no ACK, Q and LAST_SRC unchanged; ->IDLE.
//   ACK:
//     - ACK_gsel high for exactly this cycle; cleared at the next edge.
//     - REQ_gsel low: ->IDLE. Otherwise ->RELEASE.
//   RELEASE:
//     - Wait, unbounded, for REQ_gsel low; then ->IDLE. No timeout.
//   Latency: REQ sampled high at edge 0 -> Q updated and ACK high after edge 1;
//     ACK low after edge 2.
//   Write rate: at most one write per 3 cycles.
//   Non-granted requester: its REQ is ignored outside IDLE and stays pending;
//     it is never acknowledged without a write.
//   Q changes only on a LOAD->ACK transition or on reset.
//   ACK_A and ACK_B are never high together.
//   DATA_x is sampled only at the LOAD edge and must be stable in that cycle.
//   Q is a plain register copy of DATA: no arithmetic, no width conversion.
// CONFIGURATION
//   Macro ARB_ROUND_ROBIN_EN.
//   Defined: on a simultaneous REQ in IDLE, grant goes to ~LAST_SRC. The first contest after
//     reset therefore goes to A, and consecutive contests alternate A,B,A,...
//   Undefined: fixed priority; A always wins a simultaneous REQ. B can starve.
//   LAST_SRC is still updated in both builds.
// TESTING
//   1. Reset: assert RST mid-LOAD with Q=8'h3C -> Q=0, ACK_A=ACK_B=0, BUSY=0, LAST_SRC=1,
//      all immediately, without waiting for a clock edge.
//   2. Single write: REQ_A=1, DATA_A=8'hA5 -> Q=8'hA5 and ACK_A=1 one cycle after LOAD;
//      ACK_A=1 for exactly 1 cycle; LAST_SRC=0; BUSY held until REQ_A drops.
//   3. Contest, round robin (ARB_ROUND_ROBIN_EN defined): REQ_A=REQ_B=1 held, DATA_A=8'h11,
//      DATA_B=8'h22, each requester drops REQ after its ACK and re-raises it ->
//      Q sequence 11,22,11,22.
//   4. Contest, fixed priority (macro undefined): same stimulus as 3 -> Q stays 8'h11;
//      ACK_B never asserts.
//   5. Abort: REQ_B=1 for one cycle only, so it is low in LOAD -> no ACK_B;
//      Q and LAST_SRC unchanged; back to IDLE with BUSY=0.
//   6. Hold: REQ_A held high after ACK_A for 10 cycles -> stays in RELEASE, BUSY=1;
//      pending REQ_B not granted until REQ_A=0; Q constant throughout.

Source files
------------

// File: rtl/reg8_load_arbiter.sv
// Two-requester arbiter guarding one shared WIDTH-bit register; every write is a four-phase REQ/ACK.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requests alternate; otherwise A has fixed priority.
module reg8_load_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_A,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic             REQ_B,
  input  logic [WIDTH-1:0] DATA_B,
  output logic             ACK_A,
  output logic             ACK_B,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             LAST_SRC,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t     state;
  logic       gsel;
  logic       req_g;
  logic       pick;
  logic [WIDTH-1:0] data_g;

  // Handshake: a requester raises REQ and holds DATA stable; ACK pulses for one cycle
  // when DATA has been written; the requester must then drop REQ before the arbiter
  // returns to IDLE. A non-granted REQ simply stays pending until the next IDLE.
  assign req_g  = gsel ? REQ_B  : REQ_A;
  assign data_g = gsel ? DATA_B : DATA_A;
  assign BUSY      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    pick = 1'b0;
    if (REQ_A && REQ_B) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = ~LAST_SRC;
`else
      pick = 1'b0;
`endif
    end else if (REQ_B) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      gsel     <= 1'b0;
      Q        <= '0;
      ACK_A    <= 1'b0;
      ACK_B    <= 1'b0;
      LAST_SRC <= 1'b1;
    end else begin
      ACK_A <= 1'b0;
      ACK_B <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_A || REQ_B) begin
            gsel  <= pick;
            state <= LOAD;
          end
        end
        LOAD: begin
          // A requester that withdrew before its write slot is dropped silently.
          if (req_g) begin
            Q        <= data_g;
            ACK_A    <= ~gsel;
            ACK_B    <= gsel;
            LAST_SRC <= gsel;
            state    <= ACK;
          end else begin
            state <= IDLE;
          end
        end
        ACK: begin
          state <= req_g ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!req_g) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
